// File: rtl/uart_tx_core.sv
// uart_tx_core: TX FIFO plus start/data/parity/stop serialiser paced by a 16x baud tick.
// Define UART_TX_OVERFLOW_EN to add the sticky tx_overflow flag for dropped pushes.
module uart_tx_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_pulse,
  input  logic                          tx_rst,
  input  logic                          tx_push,
  input  logic [7:0]                    tx_din,
  input  logic [1:0]                    wls,
  input  logic                          stb,
  input  logic                          pen,
  input  logic                          eps,
  input  logic                          sp,
  input  logic                          bc,
  output logic                          tx_fifo_full,
  output logic                          tx_fifo_empty,
  output logic                          tx_idle,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
`ifdef UART_TX_OVERFLOW_EN
  output logic                          tx_overflow,
`endif
  output logic                          tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2 * OVERSAMPLE + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T1_C    = TW'(OVERSAMPLE);
  localparam logic [TW-1:0] T15_C   = TW'(OVERSAMPLE * 3 / 2);
  localparam logic [TW-1:0] T2_C    = TW'(2 * OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic [7:0] word_mask(input logic [1:0] w);
    case (w)
      2'b00:   return 8'h1F;
      2'b01:   return 8'h3F;
      2'b10:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Stick parity overrides; otherwise eps selects XOR of the live data bits or its inverse.
  function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] w,
                                       input logic e, input logic s);
    logic x;
    x = ^(d & word_mask(w));
    if (s) begin
      return ~e;
    end else if (e) begin
      return x;
    end else begin
      return ~x;
    end
  endfunction

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, idle_q, idle_d;
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_inc_s, target_s;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    wls_q, wls_d;
  logic          stb_q, stb_d, pen_q, pen_d, par_q, par_d;
  logic          tx_q, tx_d, line_s;
  logic          pop_s, push_ok_s, avail_s, bit_end_s;
  logic [7:0]    head_s;

  assign head_s     = mem_q[rd_ptr_q];
  assign avail_s    = (count_q != {CW{1'b0}}) && !tx_rst;
  assign tick_inc_s = tick_q + TW'(1);

  // Frame sequencing, snapshot of line format, FIFO bookkeeping and next line level.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    wls_d     = wls_q;
    stb_d     = stb_q;
    pen_d     = pen_q;
    par_d     = par_q;
    pop_s     = 1'b0;
    line_s    = 1'b1;

    if (state_q != S_STOP) begin
      target_s = T1_C;
    end else if (!stb_q) begin
      target_s = T1_C;
    end else if (wls_q == 2'b00) begin
      target_s = T15_C;
    end else begin
      target_s = T2_C;
    end
    bit_end_s = baud_pulse && (tick_inc_s == target_s) && (state_q != S_IDLE);

    if (state_q == S_IDLE) begin
      tick_d = {TW{1'b0}};
    end else if (baud_pulse) begin
      tick_d = bit_end_s ? {TW{1'b0}} : tick_inc_s;
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        if (avail_s) begin
          pop_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == (3'd4 + {1'b0, wls_q})) begin
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s && avail_s) begin
          pop_s = 1'b1;
        end else if (bit_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_s) begin
      state_d = S_START;
      tick_d  = {TW{1'b0}};
      shift_d = head_s & word_mask(wls);
      wls_d   = wls;
      stb_d   = stb;
      pen_d   = pen;
      par_d   = calc_parity(head_s, wls, eps, sp);
    end else begin
      wls_d = wls_q;
    end

    case (state_d)
      S_IDLE:   line_s = 1'b1;
      S_START:  line_s = 1'b0;
      S_DATA:   line_s = shift_d[0];
      S_PARITY: line_s = par_d;
      S_STOP:   line_s = 1'b1;
      default:  line_s = 1'b1;
    endcase
    tx_d = bc ? 1'b0 : line_s;

    push_ok_s = tx_push && !tx_rst && ((count_q != DEPTH_C) || pop_s);
    if (tx_rst) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok_s);
      rd_ptr_d = rd_ptr_q + AW'(pop_s);
      count_d  = count_q + CW'(push_ok_s) - CW'(pop_s);
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == {CW{1'b0}});
    idle_d  = empty_d && (state_d == S_IDLE);
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= tx_din;
    end
  end

  // State, datapath and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      idle_q    <= 1'b1;
      state_q   <= S_IDLE;
      tick_q    <= {TW{1'b0}};
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      wls_q     <= 2'b00;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      idle_q    <= idle_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      wls_q     <= wls_d;
      stb_q     <= stb_d;
      pen_q     <= pen_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_OVERFLOW_EN
  logic ovf_q;

  // Sticky drop flag; a flush in the same cycle takes priority over a new drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (tx_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (tx_push && !push_ok_s);
    end
  end

  assign tx_overflow = ovf_q;
`else
  // Without the flag a push into a full FIFO simply disappears.
`endif

  assign tx_fifo_full  = full_q;
  assign tx_fifo_empty = empty_q;
  assign tx_idle       = idle_q;
  assign tx_fifo_count = count_q;
  assign tx_o          = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: expected frames are queued by the stimulus and checked by a line monitor.
module tb_uart_tx_core;
  logic       clk = 1'b0;
  logic       rst_n, baud_pulse, tx_rst, tx_push;
  logic [7:0] tx_din;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, bc;
  logic       tx_fifo_full, tx_fifo_empty, tx_idle, tx_o;
  logic [4:0] tx_fifo_count;
  logic       tx_overflow;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         p_en;
    bit         par;
    int         stop;
    bit         next_b2b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  uart_tx_core #(.FIFO_DEPTH(16), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_pulse(baud_pulse), .tx_rst(tx_rst),
    .tx_push(tx_push), .tx_din(tx_din), .wls(wls), .stb(stb), .pen(pen),
    .eps(eps), .sp(sp), .bc(bc),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty), .tx_idle(tx_idle),
    .tx_fifo_count(tx_fifo_count),
`ifdef UART_TX_OVERFLOW_EN
    .tx_overflow(tx_overflow),
`endif
    .tx_o(tx_o)
  );

`ifndef UART_TX_OVERFLOW_EN
  assign tx_overflow = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lcr(input logic [1:0] w, input logic s, input logic p, input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int nbits, input bit p_en,
                              input bit par, input int stop, input bit next_b2b);
    exp_t e;
    e.data = d; e.nbits = nbits; e.p_en = p_en; e.par = par; e.stop = stop; e.next_b2b = next_b2b;
    sb.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] d);
    tx_push = 1'b1;
    tx_din  = d;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!tx_idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_idle), 32'd1);
  endtask

  // Line monitor: decodes each frame at 16 samples per bit and compares with the queue head.
  initial begin : monitor
    exp_t        e;
    logic [10:0] expb, obs;
    int          nb, bad, highs, guard;
    bit          pending;
    pending = 1'b0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        while (!(mon_en && tx_o === 1'b0)) @(negedge clk);
      end
      pending = 1'b0;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_start: got start bit expected idle line at %0t", $time);
        guard = 0;
        while (tx_o === 1'b0 && guard < 4000) begin
          @(negedge clk);
          guard++;
        end
      end else begin
        e    = sb.pop_front();
        expb = '0;
        obs  = '0;
        bad  = 0;
        for (int i = 0; i < e.nbits; i++) expb[1 + i] = e.data[i];
        if (e.p_en) expb[1 + e.nbits] = e.par;
        nb = 1 + e.nbits + (e.p_en ? 1 : 0);
        for (int b = 0; b < nb; b++) begin
          for (int i = 0; i < 16; i++) begin
            if (b != 0 || i != 0) @(negedge clk);
            if (i == 8) obs[b] = tx_o;
            if (tx_o !== expb[b]) bad++;
          end
        end
        check($sformatf("frame_bits_%02h", e.data), 32'(obs), 32'(expb));
        check($sformatf("bit_samples_%02h", e.data), 32'(bad), 32'd0);
        highs = 0;
        for (int i = 0; i < e.stop; i++) begin
          @(negedge clk);
          if (tx_o === 1'b1) highs++;
        end
        check($sformatf("stop_len_%02h", e.data), 32'(highs), 32'(e.stop));
        @(negedge clk);
        if (e.next_b2b) check("b2b_start", 32'(tx_o), 32'd0);
        pending = mon_en && (tx_o === 1'b0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst_n = 1'b0; baud_pulse = 1'b1; tx_rst = 1'b0; tx_push = 1'b0; tx_din = 8'h00; bc = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held while pushes pulse
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tx_push = ~tx_push;
      tx_din  = 8'h5A;
      check("rst_tx_o", 32'(tx_o), 32'd1);
      check("rst_empty", 32'(tx_fifo_empty), 32'd1);
      check("rst_idle", 32'(tx_idle), 32'd1);
      check("rst_full", 32'(tx_fifo_full), 32'd0);
      check("rst_count", 32'(tx_fifo_count), 32'd0);
    end
    @(negedge clk);
    tx_push = 1'b0;
    rst_n   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_count", 32'(tx_fifo_count), 32'd0);
      check("post_rst_tx_o", 32'(tx_o), 32'd1);
    end
    mon_en = 1'b1;

    // 8N1, 0xA5, idle latency
    expect_frame(8'hA5, 8, 1'b0, 1'b0, 16, 1'b0);
    push_byte(8'hA5);
    check("count_after_push", 32'(tx_fifo_count), 32'd1);
    @(negedge clk);
    check("empty_after_pop", 32'(tx_fifo_empty), 32'd1);
    check("busy_after_pop", 32'(tx_idle), 32'd0);
    n = 1;
    while (!tx_idle && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_latency_8n1", 32'(n), 32'd161);

    // 7E2 with bit 7 set (must be ignored), then stick parity both ways
    set_lcr(2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_frame(8'hC1, 7, 1'b1, 1'b0, 32, 1'b0);
    push_byte(8'hC1);
    wait_idle(600, "idle_7e2");
    set_lcr(2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_frame(8'h41, 7, 1'b1, 1'b0, 32, 1'b0);
    push_byte(8'h41);
    wait_idle(600, "idle_7s2_eps1");
    set_lcr(2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_frame(8'h41, 7, 1'b1, 1'b1, 32, 1'b0);
    push_byte(8'h41);
    wait_idle(600, "idle_7s2_eps0");

    // 6O2 0x2B, LCR changed right after the pop must not disturb the frame
    set_lcr(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h2B, 6, 1'b1, 1'b1, 32, 1'b0);
    push_byte(8'h2B);
    @(negedge clk);
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(600, "idle_6o2");

    // 5-bit, 1.5 stop, back-to-back frames
    set_lcr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame(8'h1F, 5, 1'b0, 1'b0, 24, 1'b1);
    expect_frame(8'h00, 5, 1'b0, 1'b0, 24, 1'b0);
    push_byte(8'h1F);
    push_byte(8'h00);
    wait_idle(1000, "idle_5n15_pair");

    // FIFO fill with the baud tick stalled, overflow, flush
    mon_en = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    baud_pulse = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tx_push = 1'b1;
      tx_din  = 8'(i);
      @(negedge clk);
    end
    tx_push = 1'b0;
    check("fill_count", 32'(tx_fifo_count), 32'd16);
    check("fill_full", 32'(tx_fifo_full), 32'd1);
    check("fill_ovf_clear", 32'(tx_overflow), 32'd0);
    push_byte(8'hEE);
    check("drop_count", 32'(tx_fifo_count), 32'd16);
    check("drop_full", 32'(tx_fifo_full), 32'd1);
`ifdef UART_TX_OVERFLOW_EN
    check("drop_ovf_set", 32'(tx_overflow), 32'd1);
`endif
    tx_rst  = 1'b1;
    tx_push = 1'b1;
    tx_din  = 8'h77;
    @(negedge clk);
    tx_rst  = 1'b0;
    tx_push = 1'b0;
    check("flush_count", 32'(tx_fifo_count), 32'd0);
    check("flush_empty", 32'(tx_fifo_empty), 32'd1);
    check("flush_full", 32'(tx_fifo_full), 32'd0);
    check("flush_inflight", 32'(tx_idle), 32'd0);
    check("flush_ovf_clear", 32'(tx_overflow), 32'd0);
    baud_pulse = 1'b1;
    wait_idle(400, "idle_after_flush");
    check("after_flush_count", 32'(tx_fifo_count), 32'd0);
    check("after_flush_tx_o", 32'(tx_o), 32'd1);

    // Break over a whole frame, released during the stop bit
    bc = 1'b1;
    push_byte(8'h55);
    n = 0;
    for (int k = 0; k < 150; k++) begin
      if (tx_o !== 1'b0) n++;
      @(negedge clk);
    end
    check("break_low_samples", 32'(n), 32'd0);
    check("break_fifo_popped", 32'(tx_fifo_empty), 32'd1);
    check("break_frame_running", 32'(tx_idle), 32'd0);
    bc = 1'b0;
    @(negedge clk);
    check("break_release_tx_o", 32'(tx_o), 32'd1);
    wait_idle(100, "idle_after_break");

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART transmit stage, directly downstream of the UART register file (regs_uart).
- Accepts THR writes through tx_push/tx_din into a local FIFO.
- Takes frame format from the LCR fields and bit timing from the 16x baud_out tick.
- Serialises start/data/parity/stop bits onto tx_o and returns FIFO status (THRE/TEMT) for the LSR.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2.
OVERSAMPLE, 16, baud_pulse ticks per bit period.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous reset, active-low.
baud_pulse  in  1  one-clk 16x tick (regs baud_out).
tx_rst  in  1  synchronous FIFO flush (FCR bit 2).
tx_push  in  1  THR write strobe, one clk per byte.
tx_din  in  8  THR write data.
wls  in  2  word length: 00=5 … 11=8 bits.
stb  in  1  stop bits: 0=1; 1=1.5 if wls=00, else 2.
pen  in  1  parity enable.
eps  in  1  even parity select.
sp  in  1  stick parity.
bc  in  1  break control.
tx_fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
tx_fifo_empty  out  1  FIFO empty (THRE).
tx_idle  out  1  FIFO empty and FSM in IDLE (TEMT).
tx_fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
tx_o  out  1  serial line, idle high.

Behaviour:
Reset (rst_n low, async):
- FIFO empty, count 0, FSM=IDLE, tick counter 0.
- Reset values: tx_o=1, tx_fifo_empty=1, tx_idle=1, tx_fifo_full=0.

FIFO:
- Push accepted when count<FIFO_DEPTH, or when a pop occurs in the same clk.
- Push while full with no pop is dropped, with no state change.
- Pointers wrap modulo FIFO_DEPTH.
- Status outputs are registered and reflect the post-edge state.

tx_rst:
- Clears FIFO pointers and count in one clk; a push in the same clk is dropped.
- A frame already in the shift register completes normally.

FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE/START.
- IDLE: when FIFO non-empty, the next clk pops the head, latches the shift register plus a snapshot of wls/stb/pen/eps/sp, zeroes the tick counter, enters START, and drives tx_o=0. Does not wait for baud_pulse.
- Bit period: tick counter increments on baud_pulse; a bit ends on the baud_pulse that brings the count to OVERSAMPLE, and the counter then resets.
- START: tx_o=0 for one bit period.
- DATA: 5+wls bits, LSB first, one per period; tx_din bits above the word length are ignored.
- PARITY (only if pen):
  - sp=0: bit = XOR of data bits when eps=1; inverted when eps=0.
  - sp=1: bit = ~eps.
- STOP: tx_o=1 for OVERSAMPLE ticks (1 stop), OVERSAMPLE*3/2 ticks (1.5 stop), or 2*OVERSAMPLE ticks (2 stop).
- End of STOP: if the FIFO is non-empty, pop and enter START on the same clk (back-to-back frames, no idle gap); otherwise go to IDLE.
- LCR changes mid-frame: no effect until the next frame's snapshot.

Break:
- While bc=1, tx_o is forced 0. The FSM and FIFO keep running, so frames are consumed silently.
- When bc falls, tx_o follows the FSM on the next clk.

Counting:
- tx_idle=0 from the pop clk until the clk after the last stop tick.
- baud_pulse held high continuously counts every clk.

Optional Feature:
Macro: UART_TX_OVERFLOW_EN.
- Defined:
  - Adds output tx_overflow (1 bit, reset 0).
  - Sets on a dropped push (full, no pop); sticky.
  - Cleared by tx_rst or rst_n.
  - Set and clear in the same clk: clear wins.
- Undefined: port absent; dropped pushes are silent.

Test Plan:
1. Reset with tx_push pulsing → tx_o=1, tx_fifo_empty=1, tx_idle=1, count=0 throughout; count stays 0 after rst_n release until the first push.
2. baud_pulse=1 every clk, 8N1 (wls=11, pen=0, stb=0), push 0xA5 → tx_o: 16 clk low, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then 16 clk high; tx_idle returns to 1 exactly 161 clk after the push.
3. 7E2 (wls=10, pen=1, eps=1, stb=1), push 0x41 → data 1000001, parity 0, 32-tick stop. Repeat with sp=1, eps=1 → parity bit 0. Repeat with sp=1, eps=0 → parity bit 1.
4. wls=00, stb=1, push 0x1F then 0x00 → stop lasts 24 ticks; second start bit begins on the tick right after, with no gap.
5. Hold baud_pulse=0, push 17 bytes → first byte pops, FIFO reaches 16, full=1, 18th push dropped. With UART_TX_OVERFLOW_EN, tx_overflow=1; tx_rst then clears count to 0 and tx_overflow to 0, while the in-flight frame still completes.
6. bc=1 during frame 0x55 → tx_o=0 for the whole frame; FIFO pops normally. Deassert bc mid-STOP → tx_o=1 next clk.
